// File: rtl/sdram_frame_reader.sv
// Reads a frame of packed RGB words from SDRAM and hands each word to the serial transmitter as three bytes: R, G, B.
// Optional feature macro READER_HEADER_EN: each frame is prefixed with the sync bytes 0xA5, 0x5A.
module sdram_frame_reader #(
  parameter logic [22:0] BASE_ADDR = 23'd0,
  parameter logic [22:0] NUM_WORDS = 23'd76800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        active,
  output logic        done,
  output logic [22:0] addr,
  output logic        rw,
  output logic        in_valid,
  input  logic        busy,
  input  logic [31:0] data_out,
  input  logic        out_valid,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy
);

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef READER_HEADER_EN
    S_HDR0,
    S_HDR1,
`endif
    S_REQ,
    S_WAIT,
    S_SEND_R,
    S_SEND_G,
    S_SEND_B,
    S_FIN
  } state_e;

  state_e      state_q;
  state_e      after_send_d;
  logic [22:0] addr_q;
  logic [22:0] count_q;
  logic [23:0] pix_q;
  logic        gap_q;
  logic        active_q;
  logic        done_q;
  logic        in_valid_q;
  logic [7:0]  tx_data_q;
  logic        new_tx_q;
  logic [7:0]  send_byte_d;
  logic        last_word;
  logic        unused_hi;

  // The top byte of each SDRAM word carries no pixel data.
  assign unused_hi = ^data_out[31:24];
  assign last_word = (count_q + 23'd1) == NUM_WORDS;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    send_byte_d  = pix_q[7:0];
    after_send_d = S_SEND_B;
    case (state_q)
`ifdef READER_HEADER_EN
      S_HDR0: begin
        send_byte_d  = 8'hA5;
        after_send_d = S_HDR1;
      end
      S_HDR1: begin
        send_byte_d  = 8'h5A;
        after_send_d = S_REQ;
      end
`endif
      S_SEND_R: begin
        send_byte_d  = pix_q[23:16];
        after_send_d = S_SEND_G;
      end
      S_SEND_G: send_byte_d = pix_q[15:8];
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      pix_q      <= '0;
      gap_q      <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      in_valid_q <= 1'b0;
      tx_data_q  <= '0;
      new_tx_q   <= 1'b0;
    end else begin
      new_tx_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q   <= BASE_ADDR;
            count_q  <= '0;
            gap_q    <= 1'b0;
            active_q <= 1'b1;
`ifdef READER_HEADER_EN
            state_q  <= S_HDR0;
`else
            state_q    <= S_REQ;
            in_valid_q <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (in_valid_q && !busy) begin
            in_valid_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (out_valid) begin
            pix_q   <= data_out[23:0];
            state_q <= S_SEND_R;
          end
        end
        // The cycle after each strobe is a forced gap; tx_busy is not looked at then.
`ifdef READER_HEADER_EN
        S_HDR0, S_HDR1,
`endif
        S_SEND_R, S_SEND_G: begin
          if (gap_q) begin
            gap_q      <= 1'b0;
            state_q    <= after_send_d;
            in_valid_q <= (after_send_d == S_REQ);
          end else if (!tx_busy) begin
            tx_data_q <= send_byte_d;
            new_tx_q  <= 1'b1;
            gap_q     <= 1'b1;
          end
        end
        S_SEND_B: begin
          if (gap_q) begin
            gap_q   <= 1'b0;
            count_q <= count_q + 23'd1;
            addr_q  <= addr_q + 23'd1;
            if (last_word) begin
              state_q <= S_FIN;
            end else begin
              state_q    <= S_REQ;
              in_valid_q <= 1'b1;
            end
          end else if (!tx_busy) begin
            tx_data_q <= send_byte_d;
            new_tx_q  <= 1'b1;
            gap_q     <= 1'b1;
          end
        end
        S_FIN: begin
          done_q   <= 1'b1;
          active_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign active      = active_q;
  assign done        = done_q;
  assign addr        = addr_q;
  assign rw          = 1'b0;
  assign in_valid    = in_valid_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;

endmodule
